// File: rtl/tff_pkg.sv
// Shared constants for the T flip-flop counter slice.
// Pure constants: no latency, no flow control.
package tff_pkg;
  localparam logic MODE_BANK  = 1'b0;
  localparam logic MODE_COUNT = 1'b1;
  localparam int   MAX_WIDTH  = 32;
endpackage

// File: rtl/tff_cell.sv
// One T flip-flop bit with parallel load; q and qn come from separate flops fed from one next value.
// Latency 1 cycle; no backpressure.
module tff_cell
  import tff_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic load,
  input  logic d,
  input  logic toggle,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q  <= init;
      qn <= ~init;
    end else if (load) begin
      q  <= d;
      qn <= ~d;
    end else if (toggle) begin
      q  <= ~q;
      qn <= q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// WIDTH-bit T flip-flop bank / up-down counter with load, optional saturation and terminal-count pulse.
// Latency 1 cycle from inputs to q, qn and tc; no backpressure, en simply gates stepping.
module tff_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] t,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] toggle;
  logic             at_bound;

  // Bit i flips when all lower bits sit at the direction's boundary value.
  assign carry[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = up ? (&q[i-1:0]) : ~(|q[i-1:0]);
  end

  assign at_bound = up ? (&q) : ~(|q);

  always_comb begin
    toggle = '0;
    if (en) begin
      if (mode == MODE_BANK) begin
        toggle = t;
      end else if (!(SATURATE && at_bound)) begin
        toggle = carry;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .init   (INIT[i]),
      .load   (load),
      .d      (d[i]),
      .toggle (toggle[i]),
      .q      (q[i]),
      .qn     (qn[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      tc <= 1'b0;
    end else begin
      tc <= en && (mode == MODE_COUNT) && at_bound;
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: three 4-bit instances (wrap, saturate, INIT=A) share stimulus.
// Table vectors carry expected values for the wrapping instance; a behavioural model scores all three.
module tb_tff_counter;
  import tff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, up, load;
  logic [3:0] t, d;
  logic [3:0] dq  [3];
  logic [3:0] dqn [3];
  logic       dtc [3];

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .SATURATE(1'b0), .INIT(4'h0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .up(up),
    .load(load), .d(d), .q(dq[0]), .qn(dqn[0]), .tc(dtc[0]));

  tff_counter #(.WIDTH(4), .SATURATE(1'b1), .INIT(4'h0)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .up(up),
    .load(load), .d(d), .q(dq[1]), .qn(dqn[1]), .tc(dtc[1]));

  tff_counter #(.WIDTH(4), .SATURATE(1'b0), .INIT(4'hA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .up(up),
    .load(load), .d(d), .q(dq[2]), .qn(dqn[2]), .tc(dtc[2]));

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [3:0] t;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] eq;
    logic       etc;
  } vec_t;

  typedef struct packed {
    logic [2:0][3:0] q;
    logic [2:0]      tc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mq [3];
  int         n_assert = 0;
  int         n_fail   = 0;
  vec_t       tbl [17];

  function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [3:0] tt,
                              input logic u, input logic l, input logic [3:0] dd,
                              input logic [3:0] eq, input logic etc);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.t = tt; v.up = u;
    v.load = l; v.d = dd; v.eq = eq; v.etc = etc;
    return v;
  endfunction

  // Reference behaviour written arithmetically: q+1 / q-1 with wrap or hold at the boundary.
  task automatic model(input bit sat, input logic [3:0] init, input logic [3:0] cur,
                       input vec_t v, output logic [3:0] nq, output logic ntc);
    logic bound;
    bound = v.up ? (cur == 4'hF) : (cur == 4'h0);
    if (!v.rst_n) begin
      nq = init; ntc = 1'b0;
    end else if (v.load) begin
      nq = v.d; ntc = 1'b0;
    end else if (!v.en) begin
      nq = cur; ntc = 1'b0;
    end else if (v.mode == MODE_BANK) begin
      nq = cur ^ v.t; ntc = 1'b0;
    end else begin
      ntc = bound;
      if (bound && sat) nq = cur;
      else              nq = v.up ? cur + 4'd1 : cur - 4'd1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    logic [3:0] nq;
    logic       ntc;
    @(negedge clk);
    rst_n = v.rst_n; en = v.en; mode = v.mode; t = v.t;
    up = v.up; load = v.load; d = v.d;
    for (int k = 0; k < 3; k++) begin
      model(k == 1, (k == 2) ? 4'hA : 4'h0, mq[k], v, nq, ntc);
      mq[k]   = nq;
      e.q[k]  = nq;
      e.tc[k] = ntc;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_q[%0d]", k), dq[k], e.q[k]);
      check($sformatf("model_qn[%0d]", k), dqn[k], ~e.q[k]);
      check($sformatf("model_tc[%0d]", k), {3'b0, dtc[k]}, {3'b0, e.tc[k]});
    end
    check("table_q", dq[0], v.eq);
    check("table_tc", {3'b0, dtc[0]}, {3'b0, v.etc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; t = '0; up = 1'b0; load = 1'b0; d = '0;
    for (int k = 0; k < 3; k++) mq[k] = 4'h0;

    //              rst en md  t     up ld d      q     tc
    tbl[0]  = mk(0, 1, 1, 4'hF, 1, 1, 4'hF, 4'h0, 0); // reset overrides all-high inputs
    tbl[1]  = mk(1, 1, 0, 4'h5, 0, 0, 4'h0, 4'h5, 0);
    tbl[2]  = mk(1, 1, 0, 4'h5, 0, 0, 4'h0, 4'h0, 0);
    tbl[3]  = mk(1, 0, 0, 4'hF, 0, 0, 4'h0, 4'h0, 0);
    tbl[4]  = mk(1, 1, 0, 4'hF, 1, 0, 4'h0, 4'hF, 0);
    tbl[5]  = mk(1, 1, 1, 4'h0, 1, 1, 4'h7, 4'h7, 0); // load beats counting
    tbl[6]  = mk(1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h8, 0);
    tbl[7]  = mk(1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h9, 0);
    tbl[8]  = mk(0, 1, 1, 4'h0, 1, 0, 4'h0, 4'h0, 0);
    tbl[9]  = mk(1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h1, 0);
    tbl[10] = mk(1, 1, 1, 4'h0, 0, 0, 4'h0, 4'h0, 0);
    tbl[11] = mk(1, 1, 1, 4'h0, 0, 0, 4'h0, 4'hF, 1);
    tbl[12] = mk(1, 1, 1, 4'h0, 0, 0, 4'h0, 4'hE, 0);
    tbl[13] = mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 4'hE, 0);
    tbl[14] = mk(1, 0, 1, 4'h0, 1, 1, 4'hF, 4'hF, 0);
    tbl[15] = mk(1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h0, 1);
    tbl[16] = mk(1, 1, 0, 4'h0, 1, 0, 4'h0, 4'h0, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      if (i == 0) begin
        check("init_a_q", dq[2], 4'hA);
        check("init_a_qn", dqn[2], 4'h5);
        check("init_a_tc", {3'b0, dtc[2]}, 4'h0);
      end
    end

    // Sixteen up steps from zero: tc only after the F->0 wrap.
    drive(mk(0, 0, 1, 4'h0, 1, 0, 4'h0, 4'h0, 0));
    for (int k = 1; k <= 16; k++) begin
      logic [4:0] kk;
      kk = 5'(k);
      drive(mk(1, 1, 1, 4'h0, 1, 0, 4'h0, kk[3:0], k == 16));
    end

    // Saturating down from 1, then saturating up at F; wrap instance shown alongside.
    drive(mk(1, 1, 1, 4'h0, 0, 1, 4'h1, 4'h1, 0));
    check("sat_dn_load_q", dq[1], 4'h1);
    drive(mk(1, 1, 1, 4'h0, 0, 0, 4'h0, 4'h0, 0));
    check("sat_dn1_q", dq[1], 4'h0);
    check("sat_dn1_tc", {3'b0, dtc[1]}, 4'h0);
    drive(mk(1, 1, 1, 4'h0, 0, 0, 4'h0, 4'hF, 1));
    check("sat_dn2_q", dq[1], 4'h0);
    check("sat_dn2_tc", {3'b0, dtc[1]}, 4'h1);
    drive(mk(1, 1, 1, 4'h0, 0, 0, 4'h0, 4'hE, 0));
    check("sat_dn3_q", dq[1], 4'h0);
    check("sat_dn3_tc", {3'b0, dtc[1]}, 4'h1);
    drive(mk(1, 0, 1, 4'h0, 1, 1, 4'hF, 4'hF, 0));
    drive(mk(1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h0, 1));
    check("sat_up1_q", dq[1], 4'hF);
    check("sat_up1_tc", {3'b0, dtc[1]}, 4'h1);
    drive(mk(1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h1, 0));
    check("sat_up2_q", dq[1], 4'hF);
    check("sat_up2_tc", {3'b0, dtc[1]}, 4'h1);
    drive(mk(1, 0, 1, 4'h0, 1, 0, 4'h0, 4'h1, 0));
    check("sat_idle_tc", {3'b0, dtc[1]}, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
